wb_copy_engine: RTL and testbench

Wishbone block-transfer master that fills or copies a run of 16-bit words in a Wishbone slave memory, typically the on-chip `wb_ram`, without CPU involvement. It sits directly upstream of the RAM, or of the interconnect in front of it, and drives classic pipelined Wishbone cycles. It honours `wb_stall` and keeps at most one transaction outstanding. Software or the J1 control logic programs source, destination, length and mode, pulses `start`, and waits for `done`.

---
 rtl/wb_copy_engine_if.sv | 43 ++++
 rtl/wb_copy_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_wb_copy_engine.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_copy_engine_if.sv
// ---------------------------------------------------------------------------
// wb_copy_engine_if
//
// Pipelined Wishbone (classic-pipelined) bus bundle used between the block
// copy engine and the memory slave it drives.
//
// Signals:
//   cyc, stb, we   master -> slave   cycle, strobe, write enable
//   adr  [AW]      master -> slave   word address
//   dat_w [DW]     master -> slave   write data
//   dat_r [DW]     slave  -> master  read data
//   ack            slave  -> master  transaction acknowledge
//   stall          slave  -> master  request not accepted this cycle
//
// Modports:
//   master  the copy engine side
//   slave   the memory / interconnect side
// ---------------------------------------------------------------------------
interface wb_copy_engine_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          stall;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack, stall
  );

endinterface

// File: rtl/wb_copy_engine.sv
// ---------------------------------------------------------------------------
// wb_copy_engine
//
// Wishbone block-transfer master. Fills a run of words with a constant
// pattern or copies a run of words from one address range to another,
// one word at a time, with at most one bus transaction outstanding.
//
// Ports:
//   clk_i        clock (also the Wishbone clock)
//   rst_ni       asynchronous active-low reset
//   start_i      start a transfer (sampled in IDLE only)
//   mode_i       0 = copy, 1 = fill (latched on start)
//   src_adr_i    copy source start word address (latched on start)
//   dst_adr_i    destination start word address (latched on start)
//   len_i        word count, 0 = no-op (latched on start)
//   fill_dat_i   fill pattern (latched on start)
//   abort_i      stop after the word currently in flight
//   busy_o       transfer in progress
//   done_o       one-cycle completion pulse
//   aborted_o    last transfer ended because of an abort
//   wb           Wishbone master port (see wb_copy_engine_if)
// ---------------------------------------------------------------------------
module wb_copy_engine #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [AW-1:0]     src_adr_i,
  input  logic [AW-1:0]     dst_adr_i,
  input  logic [AW-1:0]     len_i,
  input  logic [DW-1:0]     fill_dat_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  wb_copy_engine_if.master  wb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] data_q, data_d;
  logic          abort_pend_q, abort_pend_d;
  logic          aborted_q, aborted_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;

  logic          active;
  logic          stop_now;

  assign active = (state_q == S_RD_REQ)  || (state_q == S_RD_WAIT) ||
                  (state_q == S_WR_REQ)  || (state_q == S_WR_WAIT);

  // An abort raised in the very cycle the current word is acknowledged
  // still counts, so the transfer ends at this word boundary.
  assign stop_now = abort_pend_q || abort_i;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    src_d        = src_q;
    dst_d        = dst_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    data_d       = data_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;

    if (active && abort_i) begin
      abort_pend_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d       = mode_i;
          src_d        = src_adr_i;
          dst_d        = dst_adr_i;
          cnt_d        = len_i;
          fill_d       = fill_dat_i;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          if (len_i == '0) begin
            state_d = S_DONE;
          end else if (mode_i) begin
            state_d = S_WR_REQ;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end

      S_RD_REQ: begin
        if (!wb.stall) begin
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (wb.ack) begin
          data_d  = wb.dat_r;
          state_d = S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        if (!wb.stall) begin
          state_d = S_WR_WAIT;
        end
      end

      S_WR_WAIT: begin
        if (wb.ack) begin
          src_d = src_q + AW'(1);
          dst_d = dst_q + AW'(1);
          cnt_d = cnt_q - AW'(1);
          if ((cnt_q == AW'(1)) || stop_now) begin
            state_d = S_DONE;
            if (stop_now) begin
              aborted_d = 1'b1;
            end
          end else if (mode_q) begin
            state_d = S_WR_REQ;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end

      S_DONE: begin
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they are registered
  // alongside the state and line up with it cycle for cycle. Address and
  // write data come from the already-updated pointers, so they hold steady
  // while the slave stalls.
  always_comb begin
    cyc_d  = (state_d == S_RD_REQ) || (state_d == S_RD_WAIT) ||
             (state_d == S_WR_REQ) || (state_d == S_WR_WAIT);
    busy_d = cyc_d;
    stb_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    we_d   = (state_d == S_WR_REQ);
    done_d = (state_d == S_DONE);
    adr_d  = (state_d == S_RD_REQ) ? src_d : dst_d;
    dat_d  = mode_d ? fill_d : data_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      fill_q       <= '0;
      data_q       <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      data_q       <= data_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign aborted_o = aborted_q;
  assign wb.cyc    = cyc_q;
  assign wb.stb    = stb_q;
  assign wb.we     = we_q;
  assign wb.adr    = adr_q;
  assign wb.dat_w  = dat_q;

endmodule

// File: tb/tb_wb_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_wb_copy_engine
//
// Drives wb_copy_engine against a behavioural Wishbone memory slave.
// A reference model computes, at transfer start, the list of reads and
// writes the transfer must perform and pushes them into scoreboard queues;
// an independent monitor pops and compares on every accepted bus request
// and on every done pulse.
// ---------------------------------------------------------------------------
module tb_wb_copy_engine;

  localparam int AW = 16;
  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] srcAdr = '0;
  logic [15:0] dstAdr = '0;
  logic [15:0] len = '0;
  logic [15:0] fillDat = '0;
  logic        busy;
  logic        done;
  logic        aborted;

  wb_copy_engine_if #(.AW(AW), .DW(DW)) wb ();

  wb_copy_engine #(.AW(AW), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .mode_i     (mode),
    .src_adr_i  (srcAdr),
    .dst_adr_i  (dstAdr),
    .len_i      (len),
    .fill_dat_i (fillDat),
    .abort_i    (abort),
    .busy_o     (busy),
    .done_o     (done),
    .aborted_o  (aborted),
    .wb         (wb.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit [15:0] mem    [0:65535];
  bit [15:0] refMem [0:65535];

  logic        bdWe = 1'b0;
  logic [15:0] bdAdr = '0;
  logic [15:0] bdDat = '0;

  int          ackCnt = 0;
  logic [15:0] rdLatch = '0;
  int          forceStall = 0;
  bit          randStall = 1'b0;
  bit          randLat = 1'b0;

  typedef struct packed {
    logic [15:0] adr;
    logic [15:0] dat;
  } wr_t;

  wr_t         expWrites [$];
  logic [15:0] expReads  [$];
  bit          expDone   [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory slave: accepts a request at the clock edge when stall is low,
  // acks after a (possibly randomised) latency, and decides stall a little
  // after each edge so the monitor sees a settled value.
  always @(posedge clk) begin
    if (bdWe) mem[bdAdr] = bdDat;
    if (!rst_n) begin
      ackCnt = 0;
    end else if (wb.cyc === 1'b1 && wb.stb === 1'b1 && wb.stall === 1'b0) begin
      if (wb.we) mem[wb.adr] = wb.dat_w;
      else rdLatch = mem[wb.adr];
      ackCnt = randLat ? 1 + int'($urandom_range(0, 2)) : 1;
    end
    #2;
    wb.ack = 1'b0;
    if (ackCnt > 0) begin
      ackCnt--;
      if (ackCnt == 0) begin
        wb.ack   = 1'b1;
        wb.dat_r = rdLatch;
      end
    end
    if (wb.stb === 1'b1 && wb.we === 1'b1 && forceStall > 0) begin
      wb.stall = 1'b1;
      forceStall--;
    end else if (wb.stb === 1'b1 && randStall) begin
      wb.stall = ($urandom_range(0, 2) == 0);
    end else begin
      wb.stall = 1'b0;
    end
  end

  // Monitor: compares every accepted request and every done pulse with the
  // scoreboard, and checks that a stalled request is held unchanged.
  logic        prevStall = 1'b0;
  logic [15:0] prevAdr = '0;
  logic [15:0] prevDat = '0;
  logic        prevWe = 1'b0;
  wr_t         monWr;
  logic [15:0] monRd;
  bit          monAb;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prevStall) begin
        checkOutput("stallHoldAdr", wb.adr, prevAdr);
        checkOutput("stallHoldDat", wb.dat_w, prevDat);
        checkOutput("stallHoldWe", wb.we, prevWe);
        checkOutput("stallHoldStb", wb.stb, 1);
      end
      prevStall = (wb.cyc === 1'b1) && (wb.stb === 1'b1) && (wb.stall === 1'b1);
      prevAdr   = wb.adr;
      prevDat   = wb.dat_w;
      prevWe    = wb.we;
      if (wb.cyc === 1'b1 && wb.stb === 1'b1 && wb.stall === 1'b0) begin
        if (wb.we === 1'b1) begin
          if (expWrites.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedWrite actual adr=%h dat=%h required none", wb.adr, wb.dat_w);
          end else begin
            monWr = expWrites.pop_front();
            checkOutput("wrAdr", wb.adr, monWr.adr);
            checkOutput("wrDat", wb.dat_w, monWr.dat);
          end
        end else begin
          if (expReads.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedRead actual adr=%h required none", wb.adr);
          end else begin
            monRd = expReads.pop_front();
            checkOutput("rdAdr", wb.adr, monRd);
          end
        end
      end
      if (done === 1'b1) begin
        if (expDone.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedDone actual=1 required=0");
        end else begin
          monAb = expDone.pop_front();
          checkOutput("doneAborted", aborted, monAb);
          checkOutput("doneCyc", wb.cyc, 0);
          checkOutput("doneBusy", busy, 0);
        end
      end
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic preloadWord(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bdAdr = a;
    bdDat = d;
    bdWe  = 1'b1;
    @(negedge clk);
    bdWe  = 1'b0;
    refMem[a] = d;
  endtask

  // Reference model: a transfer is n sequential word moves with 16-bit
  // wrapping addresses; an abort truncates it to the aborted word count.
  task automatic applyStimulus(input bit m, input logic [15:0] s, input logic [15:0] d,
                               input logic [15:0] l, input logic [15:0] f, input int abortWords);
    int          n;
    logic [15:0] sa;
    logic [15:0] da;
    logic [15:0] v;
    n = (abortWords != 0) ? abortWords : int'(l);
    for (int i = 0; i < n; i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      if (m) begin
        v = f;
      end else begin
        v = refMem[sa];
        expReads.push_back(sa);
      end
      expWrites.push_back('{adr: da, dat: v});
      refMem[da] = v;
    end
    expDone.push_back(abortWords != 0);
    @(negedge clk);
    mode    = m;
    srcAdr  = s;
    dstAdr  = d;
    len     = l;
    fillDat = f;
    start   = 1'b1;
  endtask

  task automatic waitDone(input int abortAtRead, input bit expectBusy, output int cycles);
    int  reads;
    bit  armed;
    bit  cycDrop;
    bit  finished;
    reads    = 0;
    armed    = 1'b0;
    cycDrop  = 1'b0;
    finished = 1'b0;
    cycles   = 0;
    while (!finished && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (armed) begin
        abort = 1'b1;
        armed = 1'b0;
      end else begin
        abort = 1'b0;
      end
      if (cycles == 1) checkOutput("busyAfterStart", busy, expectBusy);
      if (wb.cyc === 1'b1 && wb.stb === 1'b1 && wb.we === 1'b0 && wb.stall === 1'b0) begin
        reads++;
        if (abortAtRead != 0 && reads == abortAtRead) armed = 1'b1;
      end
      if (done === 1'b1) finished = 1'b1;
      else if (expectBusy && wb.cyc !== 1'b1) cycDrop = 1'b1;
    end
    abort = 1'b0;
    if (!finished) begin
      total++;
      bad++;
      $display("[TB] FAIL doneTimeout actual=none required=done within 2000 cycles");
    end
    checkOutput("cycContinuous", cycDrop, 0);
  endtask

  task automatic checkMemRange(input logic [15:0] a, input int n);
    logic [15:0] x;
    for (int i = 0; i < n; i++) begin
      x = a + 16'(i);
      checkOutput("memReadback", mem[x], refMem[x]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cyc;
    bit          m;
    logic [15:0] s;
    logic [15:0] d;
    logic [15:0] l;
    logic [15:0] f;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstAborted", aborted, 0);
    checkOutput("rstCyc", wb.cyc, 0);
    checkOutput("rstStb", wb.stb, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] fill len=4 at 0x0010");
    applyStimulus(1'b1, 16'h0000, 16'h0010, 16'd4, 16'hA5A5, 0);
    waitDone(0, 1'b1, cyc);
    checkOutput("fillCycles", cyc, 9);
    checkMemRange(16'h0010, 4);

    $display("[TB] copy len=3 from 0x0000 to 0x0100");
    preloadWord(16'h0000, 16'h1111);
    preloadWord(16'h0001, 16'h2222);
    preloadWord(16'h0002, 16'h3333);
    applyStimulus(1'b0, 16'h0000, 16'h0100, 16'd3, 16'h0000, 0);
    waitDone(0, 1'b1, cyc);
    checkOutput("copyCycles", cyc, 13);
    checkMemRange(16'h0100, 3);

    $display("[TB] zero length with abort held in idle");
    abort = 1'b1;
    applyStimulus(1'b1, 16'h0000, 16'h0500, 16'd0, 16'hFFFF, 0);
    waitDone(0, 1'b0, cyc);
    checkOutput("zeroLenCycles", cyc, 1);
    checkMemRange(16'h0500, 1);

    $display("[TB] fill with three forced stalls");
    forceStall = 3;
    applyStimulus(1'b1, 16'h0000, 16'h0200, 16'd4, 16'h3C3C, 0);
    waitDone(0, 1'b1, cyc);
    checkOutput("stallCycles", cyc, 12);
    checkMemRange(16'h0200, 4);

    $display("[TB] fill wrapping at 0xFFFF");
    applyStimulus(1'b1, 16'h0000, 16'hFFFF, 16'd2, 16'h7E57, 0);
    waitDone(0, 1'b1, cyc);
    checkOutput("wrapCycles", cyc, 5);
    checkMemRange(16'hFFFF, 2);

    $display("[TB] copy len=8 aborted during word 3");
    for (int i = 0; i < 8; i++) preloadWord(16'h0300 + 16'(i), 16'hC000 + 16'(i * 17));
    applyStimulus(1'b0, 16'h0300, 16'h0400, 16'd8, 16'h0000, 3);
    waitDone(3, 1'b1, cyc);
    checkOutput("abortCycles", cyc, 13);
    checkMemRange(16'h0400, 8);

    $display("[TB] randomised transfers with stalls and ack latency");
    randStall = 1'b1;
    randLat   = 1'b1;
    for (int t = 0; t < 12; t++) begin
      m = 1'($urandom_range(0, 1));
      s = 16'($urandom);
      d = 16'($urandom);
      l = 16'($urandom_range(1, 8));
      f = 16'($urandom);
      if (!m) begin
        for (int i = 0; i < int'(l); i++) preloadWord(s + 16'(i), 16'($urandom));
      end
      applyStimulus(m, s, d, l, f, 0);
      waitDone(0, 1'b1, cyc);
      checkMemRange(d, int'(l));
    end
    randStall = 1'b0;
    randLat   = 1'b0;

    $display("[TB] reset in the middle of a copy");
    applyStimulus(1'b0, 16'h0300, 16'h0600, 16'd8, 16'h0000, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstCyc", wb.cyc, 0);
    checkOutput("asyncRstStb", wb.stb, 0);
    checkOutput("asyncRstBusy", busy, 0);
    checkOutput("asyncRstDone", done, 0);
    expWrites.delete();
    expReads.delete();
    expDone.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postRstBusy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
